spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_driver_if.sv | 25 ++
 rtl/spart_driver.sv | 130 +++++++++++++
 tb/tb_spart_driver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_driver_if.sv
// Control side of the SPART bus: strobe, direction and address from the driver,
// receive/transmit status flags back from the SPART.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor after reset, then echoes every received byte.
// Define SPART_DRV_RECONFIG_EN to reprogram the divisor whenever br_cfg changes.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'h0515,
  parameter logic [15:0] DIV_9600  = 16'h028A,
  parameter logic [15:0] DIV_19200 = 16'h0145,
  parameter logic [15:0] DIV_38400 = 16'h00A2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            br_cfg,
  spart_driver_if.master        bus,
  inout  wire  [7:0]            databus,
  output logic [7:0]            echo_cnt
);

  typedef enum logic [2:0] {
    StCfgLo,
    StCfgHi,
    StIdle,
    StRd,
    StWaitTbr,
    StWr
  } state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [15:0] div_sel;
  logic [7:0]  div_hi_q;
  logic [7:0]  echo_q;
  logic        drive;
  logic [7:0]  dout;
  logic        reconfig;

  always_comb begin
    case (br_cfg)
      2'b00:   div_sel = DIV_4800;
      2'b01:   div_sel = DIV_9600;
      2'b10:   div_sel = DIV_19200;
      default: div_sel = DIV_38400;
    endcase
  end

`ifdef SPART_DRV_RECONFIG_EN
  logic [1:0] cfg_q, cfg_prog_q;

  // cfg_prog_q holds the selection last written to the SPART; a mismatch waits for IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q      <= 2'b00;
      cfg_prog_q <= 2'b00;
    end else begin
      cfg_q <= br_cfg;
      if (run_q && state_q == StCfgLo) cfg_prog_q <= br_cfg;
    end
  end

  assign reconfig = (cfg_q != cfg_prog_q);
`else
  assign reconfig = 1'b0;
`endif

  // run_q holds the bus quiet until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StCfgLo;
      run_q    <= 1'b0;
      div_hi_q <= 8'h00;
      echo_q   <= 8'h00;
      echo_cnt <= 8'h00;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (run_q && state_q == StCfgLo) div_hi_q <= div_sel[15:8];
      if (state_q == StRd)             echo_q   <= databus;
      if (state_q == StWr)             echo_cnt <= echo_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.iocs    = 1'b0;
    bus.iorw    = 1'b1;
    bus.ioaddr  = 2'b00;
    drive       = 1'b0;
    dout        = 8'h00;
    if (run_q) begin
      case (state_q)
        StCfgLo: begin
          bus.iocs   = 1'b1;
          bus.iorw   = 1'b0;
          bus.ioaddr = 2'b10;
          drive      = 1'b1;
          dout       = div_sel[7:0];
          state_d    = StCfgHi;
        end
        StCfgHi: begin
          bus.iocs   = 1'b1;
          bus.iorw   = 1'b0;
          bus.ioaddr = 2'b11;
          drive      = 1'b1;
          dout       = div_hi_q;
          state_d    = StIdle;
        end
        StIdle: begin
          if (reconfig)     state_d = StCfgLo;
          else if (bus.rda) state_d = StRd;
        end
        StRd: begin
          bus.iocs = 1'b1;
          state_d  = StWaitTbr;
        end
        StWaitTbr: begin
          if (bus.tbr) state_d = StWr;
        end
        StWr: begin
          bus.iocs = 1'b1;
          bus.iorw = 1'b0;
          drive    = 1'b1;
          dout     = echo_q;
          state_d  = StIdle;
        end
        default: state_d = StCfgLo;
      endcase
    end
  end

  assign databus = drive ? dout : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: SPART-side bus model plus a write scoreboard.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  wire  [7:0] databus;
  logic [7:0] echo_cnt;

  logic       tb_oe;
  logic [7:0] tb_val;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;
  logic [7:0] exp_cnt;

  spart_driver_if bus_if ();

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus_if),
    .databus  (databus),
    .echo_cnt (echo_cnt)
  );

  assign databus = tb_oe ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  // Every bus write the driver issues must match the next expected {ioaddr, data}.
  always @(negedge clk) begin
    if (bus_if.iocs === 1'b1 && bus_if.iorw === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%b data=%h required no write",
                 bus_if.ioaddr, databus);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus_if.ioaddr, databus} !== exp_w) begin
          errors++;
          $display("FAIL bus_write got addr=%b data=%h required addr=%b data=%h",
                   bus_if.ioaddr, databus, exp_w[9:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; br_cfg = 2'b01; bus_if.rda = 1'b0; bus_if.tbr = 1'b0;
    tb_oe = 1'b1; tb_val = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b0) begin
      errors++; $display("FAIL reset_iocs got %b required 0", bus_if.iocs);
    end
    checks++;
    if (bus_if.iorw !== 1'b1 || bus_if.ioaddr !== 2'b00) begin
      errors++;
      $display("FAIL reset_iorw_addr got %b/%b required 1/00", bus_if.iorw, bus_if.ioaddr);
    end
    checks++;
    if (databus !== 8'h5A) begin
      errors++; $display("FAIL reset_hiz got %h required 5a", databus);
    end
    checks++;
    if (echo_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_echo_cnt got %h required 00", echo_cnt);
    end
  endtask

  // Entered with rst high; releases it and follows the two divisor writes into IDLE.
  task automatic test_config(input logic [1:0] cfg, input logic [7:0] lo, input logic [7:0] hi);
    br_cfg = cfg;
    exp_q.push_back({2'b10, lo});
    exp_q.push_back({2'b11, hi});
    @(posedge clk); #1;
    rst = 1'b0; tb_oe = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b1 || bus_if.ioaddr !== 2'b10) begin
      errors++;
      $display("FAIL cfg_lo got iocs=%b addr=%b required 1/10", bus_if.iocs, bus_if.ioaddr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b1 || bus_if.ioaddr !== 2'b11) begin
      errors++;
      $display("FAIL cfg_hi got iocs=%b addr=%b required 1/11", bus_if.iocs, bus_if.ioaddr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b0) begin
      errors++; $display("FAIL cfg_idle got iocs=%b required 0", bus_if.iocs);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cfg_writes got %0d pending required 0", exp_q.size());
    end
    exp_cnt = 8'h00;
    @(posedge clk); #1;
  endtask

  // Entered in IDLE just after a rising edge; returns in IDLE at the same phase.
  task automatic do_echo(input logic [7:0] val, input int unsigned stall, input bit hold_rda);
    int unsigned wait_cycles;
    wait_cycles = (stall == 0) ? 1 : stall;
    tb_val = val; tb_oe = 1'b1;
    bus_if.tbr = (stall == 0); bus_if.rda = 1'b1;
    exp_q.push_back({2'b00, val});
    exp_cnt = exp_cnt + 8'd1;
    @(posedge clk); #1;
    if (!hold_rda) bus_if.rda = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b1 || bus_if.iorw !== 1'b1 || bus_if.ioaddr !== 2'b00) begin
      errors++;
      $display("FAIL rd_strobe got %b/%b/%b required 1/1/00",
               bus_if.iocs, bus_if.iorw, bus_if.ioaddr);
    end
    checks++;
    if (databus !== val) begin
      errors++; $display("FAIL rd_bus got %h required %h", databus, val);
    end
    @(posedge clk); #1;
    tb_val = 8'h5A; tb_oe = (stall != 0);
    for (int unsigned i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.iocs !== 1'b0) begin
        errors++; $display("FAIL wait_iocs cycle %0d got %b required 0", i, bus_if.iocs);
      end
      if (stall != 0) begin
        checks++;
        if (databus !== 8'h5A) begin
          errors++; $display("FAIL wait_hiz cycle %0d got %h required 5a", i, databus);
        end
      end
      if (i == wait_cycles - 1) begin
        bus_if.tbr = 1'b1; bus_if.rda = 1'b0; tb_oe = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_if.iocs !== 1'b1 || bus_if.iorw !== 1'b0 || bus_if.ioaddr !== 2'b00) begin
      errors++;
      $display("FAIL wr_strobe got %b/%b/%b required 1/0/00",
               bus_if.iocs, bus_if.iorw, bus_if.ioaddr);
    end
    @(posedge clk); #1;
    bus_if.tbr = 1'b0;
    @(negedge clk);
    checks++;
    if (echo_cnt !== exp_cnt) begin
      errors++; $display("FAIL echo_cnt got %h required %h", echo_cnt, exp_cnt);
    end
    checks++;
    if (bus_if.iocs !== 1'b0) begin
      errors++; $display("FAIL post_wr_idle got iocs=%b required 0", bus_if.iocs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_echo();
    do_echo(8'h41, 0, 1'b0);
    checks++;
    if (echo_cnt !== 8'h01) begin
      errors++; $display("FAIL first_echo_cnt got %h required 01", echo_cnt);
    end
  endtask

  task automatic test_tbr_stall();
    do_echo(8'hC7, 10, 1'b0);
  endtask

  task automatic test_rda_hold();
    do_echo(8'h3C, 0, 1'b1);
    do_echo(8'h96, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_echo(8'h00, 0, 1'b0);
    do_echo(8'hFF, 0, 1'b0);
    do_echo(8'hA5, 1, 1'b0);
  endtask

  task automatic test_reconfig();
    br_cfg = 2'b11;
`ifdef SPART_DRV_RECONFIG_EN
    exp_q.push_back({2'b10, 8'hA2});
    exp_q.push_back({2'b11, 8'h00});
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifndef SPART_DRV_RECONFIG_EN
      checks++;
      if (bus_if.iocs !== 1'b0) begin
        errors++; $display("FAIL reconfig_quiet cycle %0d got iocs=%b required 0", i, bus_if.iocs);
      end
`endif
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reconfig_writes got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    tb_val = 8'h77; tb_oe = 1'b1; bus_if.rda = 1'b1; bus_if.tbr = 1'b1;
    @(posedge clk); #1;
    bus_if.rda = 1'b0;
    @(posedge clk); #1;
    tb_oe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.iocs !== 1'b1 || bus_if.iorw !== 1'b0) begin
      errors++; $display("FAIL mid_wr_reached got %b/%b required 1/0", bus_if.iocs, bus_if.iorw);
    end
    // The aborted write never reaches the scoreboard; any later replay shows as unexpected.
    rst = 1'b1; bus_if.tbr = 1'b0;
    #1;
    tb_val = 8'h5A; tb_oe = 1'b1;
    #1;
    checks++;
    if (bus_if.iocs !== 1'b0) begin
      errors++; $display("FAIL mid_rst_iocs got %b required 0", bus_if.iocs);
    end
    checks++;
    if (databus !== 8'h5A) begin
      errors++; $display("FAIL mid_rst_hiz got %h required 5a", databus);
    end
    checks++;
    if (echo_cnt !== 8'h00) begin
      errors++; $display("FAIL mid_rst_echo_cnt got %h required 00", echo_cnt);
    end
    test_config(2'b00, 8'h15, 8'h05);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) do_echo(8'(i * 37 + 11), 0, 1'b0);
    checks++;
    if (echo_cnt !== 8'h00) begin
      errors++; $display("FAIL wrap got %h required 00", echo_cnt);
    end
  endtask

  initial begin
    exp_cnt = 8'h00;
    test_reset();
    test_config(2'b01, 8'h8A, 8'h02);
    test_echo();
    test_tbr_stall();
    test_rda_hold();
    test_back_to_back();
    test_reconfig();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
